// File: rtl/tgif_pkg.sv
// Shared definitions for the cipher state load/unload datapath.
// Holds the default geometry and the unload FSM encoding.
package tgif_pkg;

  localparam int STATE_W        = 128;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / 8;

  typedef enum logic {
    UL_IDLE,
    UL_SEND
  } ul_state_e;

endpackage

// File: rtl/state_unload_ser_byte_mask_gen.sv
// Combinational byte mask: byte k of the word (k=0 is the MS byte) is all ones when k < rem_i.
// Shared between the unload serializer and the input-side padding logic.
module byte_mask_gen
  import tgif_pkg::*;
#(
  parameter int W   = WORD_W,
  parameter int NBW = 5
) (
  input  logic [NBW-1:0] rem_i,
  output logic [W-1:0]   mask_o
);

  for (genvar k = 0; k < W / 8; k++) begin : g_byte
    assign mask_o[W-1-8*k -: 8] = (rem_i > NBW'(k)) ? 8'hFF : 8'h00;
  end

endmodule

// File: rtl/state_unload_ser.sv
// Unload serializer: captures a WIDTH-bit state snapshot and streams it MS word first on a
// valid/ready bus, zeroing bytes past the last valid byte and flagging the final word.
module state_unload_ser
  import tgif_pkg::*;
#(
  parameter int WIDTH = STATE_W,
  parameter int W     = WORD_W,
  parameter int NBW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] state_in,
  input  logic [NBW-1:0]   nbytes,
  output logic             ld_rdy,
  output logic [W-1:0]     do_data,
  output logic             do_valid,
  input  logic             do_ready,
  output logic             do_last
);

  localparam int             BPW        = W / 8;
  localparam logic [NBW-1:0] MAX_BYTES  = NBW'(WIDTH / 8);
  localparam logic [NBW-1:0] WORD_BYTES = NBW'(BPW);

  ul_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [NBW-1:0]   rem_q, rem_d;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [W-1:0]     mask_d;
  logic [NBW-1:0]   nb_clamped;
  logic             hs;

  assign nb_clamped = (nbytes > MAX_BYTES) ? MAX_BYTES : nbytes;
  assign hs         = valid_q & do_ready;

  // Mask is built from the next-state byte count so the output word can be registered.
  byte_mask_gen #(
    .W   (W),
    .NBW (NBW)
  ) u_mask (
    .rem_i  (rem_d),
    .mask_o (mask_d)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    case (state_q)
      UL_IDLE: begin
        if (ld && (nbytes != '0)) begin
          shreg_d = state_in;
          rem_d   = nb_clamped;
          state_d = UL_SEND;
        end
      end
      UL_SEND: begin
        if (hs) begin
          if (last_q) begin
            state_d = UL_IDLE;
          end else begin
            shreg_d = shreg_q << W;
            rem_d   = rem_q - WORD_BYTES;
          end
        end
      end
    endcase
  end

  always_comb begin
    valid_d = (state_d == UL_SEND);
    data_d  = valid_d ? (shreg_d[WIDTH-1 -: W] & mask_d) : '0;
    last_d  = valid_d && (rem_d <= WORD_BYTES);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= UL_IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // Snapshot and byte count are only meaningful while sending.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    rem_q   <= rem_d;
  end

  assign ld_rdy   = (state_q == UL_IDLE);
  assign do_valid = valid_q;
  assign do_data  = data_q;
  assign do_last  = last_q;

endmodule

// File: tb/tb_state_unload_ser.sv
// Bench for state_unload_ser: vector table, hand-written corner sequences and random traffic
// checked every cycle against a queue-based model of the expected word stream.
module tb_state_unload_ser;

  localparam int WIDTH = 128;
  localparam int W     = 32;
  localparam int NBW   = 5;
  localparam int BPW   = W / 8;
  localparam int NB    = WIDTH / 8;

  localparam logic [WIDTH-1:0] S1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [WIDTH-1:0] S2 = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld;
  logic [WIDTH-1:0] state_in;
  logic [NBW-1:0]   nbytes;
  logic             ld_rdy;
  logic [W-1:0]     do_data;
  logic             do_valid;
  logic             do_ready;
  logic             do_last;

  always #5 clk = ~clk;

  state_unload_ser #(
    .WIDTH (WIDTH),
    .W     (W),
    .NBW   (NBW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .state_in (state_in),
    .nbytes   (nbytes),
    .ld_rdy   (ld_rdy),
    .do_data  (do_data),
    .do_valid (do_valid),
    .do_ready (do_ready),
    .do_last  (do_last)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } word_t;

  typedef struct {
    logic [WIDTH-1:0] st;
    logic [NBW-1:0]   nb;
    int               nw;
    logic [W-1:0]     w0;
    logic [W-1:0]     wl;
  } vec_t;

  word_t        exp_q[$];
  vec_t         vec[8];
  int           tests = 0;
  int           fails = 0;
  int           hs_cnt;
  logic [W-1:0] hs_first;
  logic [W-1:0] hs_lastw;
  logic         hs_last_flag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Expected stream: clamp the count, zero every byte past it, cut into MS-first words.
  task automatic model_load(input logic [WIDTH-1:0] st, input logic [NBW-1:0] nb);
    int          n;
    int          nw;
    logic [7:0]  bytes[NB];
    word_t       w;
    n  = (int'(nb) > NB) ? NB : int'(nb);
    nw = (n + BPW - 1) / BPW;
    for (int b = 0; b < NB; b++) bytes[b] = (b < n) ? st[WIDTH-1-8*b -: 8] : 8'h00;
    for (int i = 0; i < nw; i++) begin
      w.data = '0;
      for (int k = 0; k < BPW; k++) w.data = {w.data[W-9:0], bytes[i*BPW+k]};
      w.last = (i == nw - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic cycle();
    word_t w;
    bit    idle;
    @(negedge clk);
    if (rst) begin
      idle = (exp_q.size() == 0);
      check("ld_rdy", 32'(ld_rdy), 32'(idle));
      check("do_valid", 32'(do_valid), 32'(!idle));
      if (do_valid && !idle) begin
        w = exp_q[0];
        check("do_data", do_data, w.data);
        check("do_last", 32'(do_last), 32'(w.last));
        if (do_ready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
          if (hs_cnt == 1) hs_first = do_data;
          hs_lastw     = do_data;
          hs_last_flag = do_last;
        end
      end
      if (ld && idle && (nbytes != '0)) model_load(state_in, nbytes);
    end else begin
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0] = '{S1, 5'd16, 4, 32'h00112233, 32'hCCDDEEFF};
    vec[1] = '{S1, 5'd6,  2, 32'h00112233, 32'h44550000};
    vec[2] = '{S1, 5'd0,  0, 32'h00000000, 32'h00000000};
    vec[3] = '{S1, 5'd31, 4, 32'h00112233, 32'hCCDDEEFF};
    vec[4] = '{S2, 5'd13, 4, 32'hFEDCBA98, 32'h4B000000};
    vec[5] = '{S2, 5'd1,  1, 32'hFE000000, 32'hFE000000};
    vec[6] = '{S2, 5'd9,  3, 32'hFEDCBA98, 32'h0F000000};
    vec[7] = '{S2, 5'd4,  1, 32'hFEDCBA98, 32'hFEDCBA98};

    rst = 1'b0; ld = 1'b0; do_ready = 1'b0; state_in = '0; nbytes = '0;
    hs_cnt = 0; hs_first = '0; hs_lastw = '0; hs_last_flag = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_ld_rdy", 32'(ld_rdy), 32'd1);
    check("rst_do_valid", 32'(do_valid), 32'd0);
    check("rst_do_last", 32'(do_last), 32'd0);
    check("rst_do_data", do_data, 32'h0);
    @(posedge clk);
    #1;

    foreach (vec[i]) begin
      state_in = vec[i].st; nbytes = vec[i].nb; ld = 1'b1; do_ready = 1'b1; hs_cnt = 0;
      cycle();
      ld = 1'b0;
      for (int c = 0; c < 8; c++) cycle();
      check("vec_nwords", hs_cnt, vec[i].nw);
      if (vec[i].nw > 0) begin
        check("vec_first", hs_first, vec[i].w0);
        check("vec_lastw", hs_lastw, vec[i].wl);
        check("vec_lastflag", 32'(hs_last_flag), 32'd1);
      end
    end

    // Stalls with an ignored mid-send load.
    state_in = S1; nbytes = 5'd16; ld = 1'b1; do_ready = 1'b0; hs_cnt = 0;
    cycle();
    ld = 1'b0;
    for (int c = 0; c < 16; c++) begin
      do_ready = ((c % 3) == 0);
      ld       = (c == 2);
      state_in = (c == 2) ? S2 : S1;
      cycle();
    end
    ld = 1'b0; do_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    check("stall_nwords", hs_cnt, 4);
    check("stall_lastw", hs_lastw, 32'hCCDDEEFF);

    // Reset mid-transfer, then a fresh single-word load.
    state_in = S1; nbytes = 5'd16; ld = 1'b1; do_ready = 1'b1; hs_cnt = 0;
    cycle();
    ld = 1'b0;
    cycle();
    cycle();
    check("pre_rst_nwords", hs_cnt, 2);
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst2_do_valid", 32'(do_valid), 32'd0);
    check("rst2_ld_rdy", 32'(ld_rdy), 32'd1);
    @(posedge clk);
    #1;
    state_in = S2; nbytes = 5'd4; ld = 1'b1; hs_cnt = 0;
    cycle();
    ld = 1'b0;
    for (int c = 0; c < 6; c++) cycle();
    check("rst2_nwords", hs_cnt, 1);
    check("rst2_word", hs_first, 32'hFEDCBA98);
    check("rst2_last", 32'(hs_last_flag), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 63) != 0);
      ld       = ($urandom_range(0, 3) == 0);
      do_ready = ($urandom_range(0, 3) != 0);
      nbytes   = NBW'($urandom_range(0, 31));
      state_in = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    rst = 1'b1; ld = 1'b0; do_ready = 1'b1;
    for (int c = 0; c < 8; c++) cycle();
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
